// File: rtl/golden_counter.sv
// golden_counter: network-wide golden packet identifier generator.
// Rotates {pktID, srcX, srcY} through every (source, pktID) pair.
// Each identity holds for a fixed epoch, or less if the golden packet
// is reported ejected first. Every router's golden comparator consumes
// counterGolden unmodified.
module golden_counter #(
  parameter int X_BITS     = 3,
  parameter int Y_BITS     = 3,
  parameter int PKTID_BITS = 4,
  parameter int NUM_X      = 8,
  parameter int NUM_Y      = 8,
  parameter int NUM_PKTID  = 16,
  parameter int EPOCH_LEN  = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               golden_done,
  output logic [PKTID_BITS+X_BITS+Y_BITS-1:0] counterGolden,
  output logic                               epoch_tick,
  output logic                               sweep_wrap
);

  localparam int CNT_W = $clog2(EPOCH_LEN);

  logic [CNT_W-1:0]      cycle_cnt_r;
  logic [PKTID_BITS-1:0] pktid_r;
  logic [X_BITS-1:0]     srcx_r;
  logic [Y_BITS-1:0]     srcy_r;
  logic                  epoch_tick_r;
  logic                  sweep_wrap_r;

  logic                  cnt_last_s;
  logic                  pkt_last_s;
  logic                  x_last_s;
  logic                  y_last_s;
  logic                  adv_s;
  logic                  wrap_s;
  logic [PKTID_BITS-1:0] pktid_nxt_s;
  logic [X_BITS-1:0]     srcx_nxt_s;
  logic [Y_BITS-1:0]     srcy_nxt_s;

  // Field-limit detection and the advance decision. golden_done only
  // counts while enabled, so a pulse during a freeze is simply lost.
  always_comb begin
    cnt_last_s = (cycle_cnt_r == CNT_W'(EPOCH_LEN - 1));
    pkt_last_s = (pktid_r == PKTID_BITS'(NUM_PKTID - 1));
    x_last_s   = (srcx_r == X_BITS'(NUM_X - 1));
    y_last_s   = (srcy_r == Y_BITS'(NUM_Y - 1));
    adv_s      = enable & (cnt_last_s | golden_done);
    wrap_s     = pkt_last_s & x_last_s & y_last_s;
  end

  // Next identity: pktID is the fastest digit, then srcY, then srcX.
  // Each digit wraps at its NUM_* limit, so unused codes never appear.
  always_comb begin
    pktid_nxt_s = pktid_r;
    srcx_nxt_s  = srcx_r;
    srcy_nxt_s  = srcy_r;
    if (!pkt_last_s) begin
      pktid_nxt_s = pktid_r + PKTID_BITS'(1);
    end else begin
      pktid_nxt_s = {PKTID_BITS{1'b0}};
      if (!y_last_s) begin
        srcy_nxt_s = srcy_r + Y_BITS'(1);
      end else begin
        srcy_nxt_s = {Y_BITS{1'b0}};
        if (!x_last_s) begin
          srcx_nxt_s = srcx_r + X_BITS'(1);
        end else begin
          srcx_nxt_s = {X_BITS{1'b0}};
        end
      end
    end
  end

  // Epoch timer, golden identity and the one-cycle tick/wrap strobes.
  // An advance restarts the timer so the new identity gets a full epoch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_r  <= {CNT_W{1'b0}};
      pktid_r      <= {PKTID_BITS{1'b0}};
      srcx_r       <= {X_BITS{1'b0}};
      srcy_r       <= {Y_BITS{1'b0}};
      epoch_tick_r <= 1'b0;
      sweep_wrap_r <= 1'b0;
    end else if (adv_s) begin
      cycle_cnt_r  <= {CNT_W{1'b0}};
      pktid_r      <= pktid_nxt_s;
      srcx_r       <= srcx_nxt_s;
      srcy_r       <= srcy_nxt_s;
      epoch_tick_r <= 1'b1;
      sweep_wrap_r <= wrap_s;
    end else if (enable) begin
      cycle_cnt_r  <= cycle_cnt_r + CNT_W'(1);
      epoch_tick_r <= 1'b0;
      sweep_wrap_r <= 1'b0;
    end else begin
      epoch_tick_r <= 1'b0;
      sweep_wrap_r <= 1'b0;
    end
  end

  assign counterGolden = {pktid_r, srcx_r, srcy_r};
  assign epoch_tick    = epoch_tick_r;
  assign sweep_wrap    = sweep_wrap_r;

endmodule

// File: tb/tb_golden_counter.sv
// tb_golden_counter: directed, table-driven bench for golden_counter.
// Instance u_dut uses default parameters; u_small uses a 2x2x2 space
// with a 4-cycle epoch to walk the whole carry chain.
module tb_golden_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       gd;
  logic [9:0] cg;
  logic       tick;
  logic       wrap;

  logic       rst2;
  logic       en2;
  logic       gd2;
  logic [2:0] cg2;
  logic       tick2;
  logic       wrap2;

  int n_checks;
  int n_fail;

  typedef struct {
    logic       en;
    logic       gd;
    logic [9:0] exp_cg;
    logic       exp_tick;
  } vec_t;

  vec_t vecs[9];
  logic [2:0] chain[8];

  golden_counter u_dut (
    .clk(clk), .reset(rst), .enable(en), .golden_done(gd),
    .counterGolden(cg), .epoch_tick(tick), .sweep_wrap(wrap)
  );

  golden_counter #(
    .X_BITS(1), .Y_BITS(1), .PKTID_BITS(1),
    .NUM_X(2), .NUM_Y(2), .NUM_PKTID(2), .EPOCH_LEN(4)
  ) u_small (
    .clk(clk), .reset(rst2), .enable(en2), .golden_done(gd2),
    .counterGolden(cg2), .epoch_tick(tick2), .sweep_wrap(wrap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] gv(input int p, input int x, input int y);
    return {4'(p), 3'(x), 3'(y)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; en = 1'b0; gd = 1'b0;
    rst2 = 1'b1; en2 = 1'b0; gd2 = 1'b0;

    // Per-cycle vectors applied right after the mid-run reset release.
    vecs[0] = '{1'b1, 1'b1, gv(1,0,0), 1'b1};  // back-to-back #1
    vecs[1] = '{1'b1, 1'b1, gv(2,0,0), 1'b1};  // back-to-back #2
    vecs[2] = '{1'b1, 1'b1, gv(3,0,0), 1'b1};  // back-to-back #3
    vecs[3] = '{1'b1, 1'b0, gv(3,0,0), 1'b0};  // tick drops
    vecs[4] = '{1'b0, 1'b1, gv(3,0,0), 1'b0};  // frozen, done ignored
    vecs[5] = '{1'b0, 1'b0, gv(3,0,0), 1'b0};  // frozen, not latched
    vecs[6] = '{1'b1, 1'b0, gv(3,0,0), 1'b0};  // counting resumes
    vecs[7] = '{1'b1, 1'b1, gv(4,0,0), 1'b1};  // early advance
    vecs[8] = '{1'b1, 1'b0, gv(4,0,0), 1'b0};

    // Small-instance sequence, {pkt, x, y}: pkt fastest, then y, then x.
    chain[0] = 3'b100; chain[1] = 3'b001; chain[2] = 3'b101; chain[3] = 3'b010;
    chain[4] = 3'b110; chain[5] = 3'b011; chain[6] = 3'b111; chain[7] = 3'b000;

    // Reset state.
    step(2);
    chk("reset_cg", 32'(cg), 32'(0));
    chk("reset_tick", 32'(tick), 32'(0));
    chk("reset_wrap", 32'(wrap), 32'(0));

    // Timer: first advance on the 64th edge after release.
    rst = 1'b0; en = 1'b1;
    step(63);
    chk("timer_pre_cg", 32'(cg), 32'(gv(0,0,0)));
    chk("timer_pre_tick", 32'(tick), 32'(0));
    step(1);
    chk("timer_adv_cg", 32'(cg), 32'(gv(1,0,0)));
    chk("timer_adv_tick", 32'(tick), 32'(1));
    chk("timer_adv_wrap", 32'(wrap), 32'(0));
    step(1);
    chk("timer_tick_one_cycle", 32'(tick), 32'(0));
    chk("timer_hold_cg", 32'(cg), 32'(gv(1,0,0)));

    // Drive to {5,2,3} (index 309) with back-to-back dones, then 40 cycles.
    gd = 1'b1;
    step(308);
    gd = 1'b0;
    chk("build_cg", 32'(cg), 32'(gv(5,2,3)));
    step(40);
    chk("midrun_cg", 32'(cg), 32'(gv(5,2,3)));
    chk("midrun_tick", 32'(tick), 32'(0));

    // Asynchronous reset mid-cycle: outputs clear without a clock edge.
    rst = 1'b1;
    #2;
    chk("async_rst_cg", 32'(cg), 32'(0));
    chk("async_rst_tick", 32'(tick), 32'(0));
    chk("async_rst_wrap", 32'(wrap), 32'(0));
    step(1);
    rst = 1'b0;

    // Table-driven: back-to-back, freeze, early advance.
    for (int i = 0; i < 9; i++) begin
      en = vecs[i].en;
      gd = vecs[i].gd;
      step(1);
      chk($sformatf("vec%0d_cg", i), 32'(cg), 32'(vecs[i].exp_cg));
      chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].exp_tick));
      chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(0));
    end
    gd = 1'b0; en = 1'b1;

    // Early advance at cycle_cnt = 10 (timer is at 1 here).
    step(9);
    gd = 1'b1;
    step(1);
    gd = 1'b0;
    chk("early_cg", 32'(cg), 32'(gv(5,0,0)));
    chk("early_tick", 32'(tick), 32'(1));
    step(63);
    chk("early_restart_cg", 32'(cg), 32'(gv(5,0,0)));
    chk("early_restart_tick", 32'(tick), 32'(0));
    step(1);
    chk("early_next_cg", 32'(cg), 32'(gv(6,0,0)));
    chk("early_next_tick", 32'(tick), 32'(1));

    // Coincident expiry and done: one increment only.
    step(63);
    chk("coinc_pre_cg", 32'(cg), 32'(gv(6,0,0)));
    gd = 1'b1;
    step(1);
    gd = 1'b0;
    chk("coinc_cg", 32'(cg), 32'(gv(7,0,0)));
    chk("coinc_tick", 32'(tick), 32'(1));
    step(1);
    chk("coinc_tick_drop", 32'(tick), 32'(0));

    // Freeze at cycle_cnt = 20 for 100 cycles while pulsing done.
    step(19);
    en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      gd = i[0];
      step(1);
      chk("freeze_cg", 32'(cg), 32'(gv(7,0,0)));
      chk("freeze_tick", 32'(tick), 32'(0));
    end
    gd = 1'b0;
    en = 1'b1;
    // Re-enabled cycles carry cycle_cnt 20..63; the advance cycle is 43
    // cycles after the first, and its result shows after the 44th edge.
    step(43);
    chk("unfreeze_pre_cg", 32'(cg), 32'(gv(7,0,0)));
    chk("unfreeze_pre_tick", 32'(tick), 32'(0));
    step(1);
    chk("unfreeze_cg", 32'(cg), 32'(gv(8,0,0)));
    chk("unfreeze_tick", 32'(tick), 32'(1));

    // Carry chain on the small instance, one step every 4 cycles.
    rst2 = 1'b0; en2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(3);
      chk($sformatf("chain%0d_hold_tick", i), 32'(tick2), 32'(0));
      chk($sformatf("chain%0d_hold_wrap", i), 32'(wrap2), 32'(0));
      step(1);
      chk($sformatf("chain%0d_cg", i), 32'(cg2), 32'(chain[i]));
      chk($sformatf("chain%0d_tick", i), 32'(tick2), 32'(1));
      chk($sformatf("chain%0d_wrap", i), 32'(wrap2), (i == 7) ? 32'(1) : 32'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
